cpu_step_ctrl: RTL

//  Clock-enable sequencer for the my_cpu core on the FPGA board.

---
 rtl/cpu_step_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock-enable sequencer for the my_cpu core.
// Conditions the three board keys (STEP, RUN/STOP, CLEAR) and drives a
// one-cycle cpu_ce for single-step, free-run at a divided rate, or nothing
// once the core has executed HLT. It also keeps a pulse counter and status LEDs.

// Per-key conditioning: 2-flop synchronizer followed by a counting debouncer.
// 'flip' is a registered one-cycle pulse raised in the same cycle that
// 'stable' takes its new value, so the consumer can qualify it by direction.
module cpu_step_key_cond #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic flip
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer; idles at the released (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES straight clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b1;
            flip   <= 1'b0;
        end else begin
            flip <= 1'b0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= sync1;
                flip   <= 1'b1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// Top: key conditioning array, step/run/halt FSM, step counter, status LEDs.
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RUN_DIV    = 5_000_000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             key0,
    input  logic             key1,
    input  logic             key2,
    input  logic             key3,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_cnt,
    output logic [3:0]       led
);
    localparam int NUM_KEYS = 3;
    localparam int DW       = $clog2(RUN_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } st_t;

    // Key index 0 = STEP (key1), 1 = RUN/STOP (key2), 2 = CLEAR (key3)
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_flip;
    logic [NUM_KEYS-1:0] key_press;

    st_t           st;
    logic [DW-1:0] div;
    logic          halt_seen;
    logic          step_p;
    logic          run_p;
    logic          clear_p;
    logic          halt_go;
    logic          div_end;
    logic          ce_fire;

    assign key_raw = {key3, key2, key1};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        cpu_step_key_cond #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_key (
            .clk   (clk),
            .rst_n (key0),
            .raw   (key_raw[g]),
            .stable(key_stable[g]),
            .flip  (key_flip[g])
        );
        // A flip that lands on the low level is a press; releases drop out here
        assign key_press[g] = key_flip[g] & ~key_stable[g];
    end

    assign step_p  = key_press[0];
    assign run_p   = key_press[1];
    assign clear_p = key_press[2];

    // A halt that has already been serviced (and cleared) must not re-halt
    // until the core drops cpu_halt and raises it again.
    assign halt_go = cpu_halt & ~halt_seen;
    assign div_end = (div == DW'(RUN_DIV - 1));

    // Cycles in which a cpu_ce pulse is decided; priority: halt, run/stop, step/divider
    always_comb begin
        ce_fire = 1'b0;
        if (!halt_go && !run_p) begin
            if (st == IDLE && step_p)
                ce_fire = 1'b1;
            else if (st == RUN && div_end)
                ce_fire = 1'b1;
        end
    end

    // Main FSM with registered cpu_ce and run-rate divider
    always_ff @(posedge clk or negedge key0) begin
        if (!key0) begin
            st     <= IDLE;
            div    <= '0;
            cpu_ce <= 1'b0;
        end else begin
            cpu_ce <= ce_fire;
            case (st)
                IDLE: begin
                    div <= '0;
                    if (halt_go)
                        st <= HALT;
                    else if (run_p)
                        st <= RUN;
                    else if (step_p)
                        st <= STEP;
                end
                STEP: begin
                    div <= '0;
                    st  <= IDLE;
                end
                RUN: begin
                    if (halt_go) begin
                        st  <= HALT;
                        div <= '0;
                    end else if (run_p) begin
                        st  <= IDLE;
                        div <= '0;
                    end else begin
                        div <= div_end ? '0 : div + 1'b1;
                    end
                end
                HALT: begin
                    div <= '0;
                    if (clear_p)
                        st <= IDLE;
                end
                default: begin
                    st  <= IDLE;
                    div <= '0;
                end
            endcase
        end
    end

    // Remember that the current HLT has been acted on; forget it once the core drops it
    always_ff @(posedge clk or negedge key0) begin
        if (!key0)
            halt_seen <= 1'b0;
        else if (!cpu_halt)
            halt_seen <= 1'b0;
        else if (st == HALT)
            halt_seen <= 1'b1;
    end

    // Pulse counter; clear wins over a coincident increment
    always_ff @(posedge clk or negedge key0) begin
        if (!key0)
            step_cnt <= '0;
        else if (clear_p)
            step_cnt <= '0;
        else if (ce_fire)
            step_cnt <= step_cnt + 1'b1;
    end

    // Status LEDs: mode flags, a toggle per cpu_ce, and the debounced STEP key
    always_ff @(posedge clk or negedge key0) begin
        if (!key0) begin
            led <= '0;
        end else begin
            led[0] <= (st == RUN);
            led[1] <= (st == HALT);
            led[2] <= led[2] ^ ce_fire;
            led[3] <= ~key_stable[0];
        end
    end

    assign state = st;
endmodule
